// File: rtl/sfcw_sweep_sequencer.sv
// SFCW sweep sequencer: steps a frequency word, pulses synth load, waits settle, opens dwell window.
// Optional macro SWEEP_TRIANGLE_EN: after the top step the sweep walks back down to step 0.
module sfcw_sweep_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int FW       = 32,
    parameter int STEP_W   = 10,
    parameter int CNT_W    = 16
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] n_steps,
    input  logic [FW-1:0]     f_start,
    input  logic [FW-1:0]     f_step,
    input  logic [CNT_W-1:0]  settle_ticks,
    input  logic [CNT_W-1:0]  dwell_ticks,
    output logic              busy,
    output logic [FW-1:0]     freq_word,
    output logic              freq_load,
    output logic [STEP_W-1:0] step_idx,
    output logic              sample_en,
    output logic              step_done,
    output logic              sweep_done,
    output logic              cfg_err
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SETTLE, DWELL} state_t;

    state_t             state, state_nxt;
    logic [PW-1:0]      pre;
    logic [CNT_W-1:0]   tcnt;
    logic [STEP_W-1:0]  n_lat;
    logic [FW-1:0]      fstep_lat;
    logic [CNT_W-1:0]   settle_lat;
    logic [CNT_W-1:0]   dwell_lat;
    logic               dir_down;

    logic tick, settle_end, dwell_end, cfg_ok, top_step, finish, go_down;

    assign cfg_ok     = (n_steps != '0) && (dwell_ticks != '0);
    assign tick       = (pre == PW'(TICK_DIV - 1));
    assign settle_end = (state == SETTLE) && tick && (tcnt == settle_lat - CNT_W'(1));
    assign dwell_end  = (state == DWELL) && tick && (tcnt == dwell_lat - CNT_W'(1));
    assign top_step   = (step_idx == n_lat - STEP_W'(1));

`ifdef SWEEP_TRIANGLE_EN
    // Top step turns the sweep around unless it is also the only step.
    assign finish  = dir_down ? (step_idx == '0) : (top_step && n_lat == STEP_W'(1));
    assign go_down = dir_down || top_step;
`else
    assign finish  = top_step;
    assign go_down = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        freq_load = 1'b0;
        sample_en = 1'b0;
        step_done = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start && !abort && cfg_ok) state_nxt = LOAD;
            end
            LOAD: begin
                freq_load = 1'b1;
                if (abort)                  state_nxt = IDLE;
                else if (settle_lat == '0)  state_nxt = DWELL;
                else                        state_nxt = SETTLE;
            end
            SETTLE: begin
                if (abort)           state_nxt = IDLE;
                else if (settle_end) state_nxt = DWELL;
            end
            DWELL: begin
                sample_en = 1'b1;
                if (abort) state_nxt = IDLE;
                else if (dwell_end) begin
                    step_done = 1'b1;
                    state_nxt = finish ? IDLE : LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            tcnt       <= '0;
            n_lat      <= '0;
            fstep_lat  <= '0;
            settle_lat <= '0;
            dwell_lat  <= '0;
            dir_down   <= 1'b0;
            freq_word  <= '0;
            step_idx   <= '0;
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            cfg_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (cfg_ok) begin
                            n_lat      <= n_steps;
                            fstep_lat  <= f_step;
                            settle_lat <= settle_ticks;
                            dwell_lat  <= dwell_ticks;
                            freq_word  <= f_start;
                            step_idx   <= '0;
                            dir_down   <= 1'b0;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    pre  <= '0;
                    tcnt <= '0;
                end
                SETTLE, DWELL: begin
                    if (!abort) begin
                        pre <= tick ? '0 : pre + PW'(1);
                        // Tick counter restarts at the settle/dwell boundary.
                        if (tick) tcnt <= settle_end ? '0 : tcnt + CNT_W'(1);
                        if (dwell_end) begin
                            if (finish) begin
                                sweep_done <= 1'b1;
                            end else if (go_down) begin
                                dir_down  <= 1'b1;
                                step_idx  <= step_idx - STEP_W'(1);
                                freq_word <= freq_word - fstep_lat;
                            end else begin
                                step_idx  <= step_idx + STEP_W'(1);
                                freq_word <= freq_word + fstep_lat;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfcw_sweep_sequencer.sv
// Directed bench for sfcw_sweep_sequencer: timing of loads/dwell/done, cfg errors, abort, wrap, reset.
module tb_sfcw_sweep_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic        abort  = 1'b0;
    logic [9:0]  n_steps = '0;
    logic [31:0] f_start = '0;
    logic [31:0] f_step  = '0;
    logic [15:0] settle_ticks = '0;
    logic [15:0] dwell_ticks  = '0;
    logic        busy, freq_load, sample_en, step_done, sweep_done, cfg_err;
    logic [31:0] freq_word;
    logic [9:0]  step_idx;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_fw [0:7];
    logic [9:0]  exp_si [0:7];

    sfcw_sweep_sequencer #(.TICK_DIV(4), .FW(32), .STEP_W(10), .CNT_W(16)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort),
        .n_steps(n_steps), .f_start(f_start), .f_step(f_step),
        .settle_ticks(settle_ticks), .dwell_ticks(dwell_ticks),
        .busy(busy), .freq_word(freq_word), .freq_load(freq_load),
        .step_idx(step_idx), .sample_en(sample_en), .step_done(step_done),
        .sweep_done(sweep_done), .cfg_err(cfg_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_in);
        #1;
    endtask

    // Present a start during the current cycle; returns sampling cycle 1.
    task automatic do_start(input int n, input logic [31:0] fs, input logic [31:0] fi,
                            input int st, input int dw);
        n_steps = 10'(n); f_start = fs; f_step = fi;
        settle_ticks = 16'(st); dwell_ticks = 16'(dw);
        start = 1'b1;
        next_cyc();
        start = 1'b0;
    endtask

    // Checks every cycle from c1 through two cycles past sweep completion.
    task automatic sweep_check(input string nm, input int nl, input int sc, input int dc);
        int per, tot, off, s;
        logic inr;
        per = 1 + sc + dc;
        tot = nl * per;
        for (int k = 1; k <= tot + 2; k++) begin
            off = (k - 1) % per;
            s   = (k - 1) / per;
            inr = (k <= tot);
            chk($sformatf("%s_load@%0d", nm, k), 32'(freq_load), 32'(inr && off == 0));
            chk($sformatf("%s_samp@%0d", nm, k), 32'(sample_en), 32'(inr && off > sc));
            chk($sformatf("%s_sdone@%0d", nm, k), 32'(step_done), 32'(inr && off == per - 1));
            chk($sformatf("%s_wdone@%0d", nm, k), 32'(sweep_done), 32'(k == tot + 1));
            chk($sformatf("%s_busy@%0d", nm, k), 32'(busy), 32'(inr));
            if (inr && off == 0) begin
                chk($sformatf("%s_fw@%0d", nm, k), freq_word, exp_fw[s]);
                chk($sformatf("%s_idx@%0d", nm, k), 32'(step_idx), 32'(exp_si[s]));
            end
            next_cyc();
        end
    endtask

    initial begin
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fw", freq_word, 0);
        chk("rst_idx", 32'(step_idx), 0);
        chk("rst_pulses", {26'd0, freq_load, sample_en, step_done, sweep_done, cfg_err, 1'b0}, 0);
        #20 rst_n = 1'b1;
        next_cyc();

        // Nominal sweep: loads every 21 cycles, dwell 12 cycles after 8-cycle settle.
`ifdef SWEEP_TRIANGLE_EN
        exp_fw[0] = 100; exp_fw[1] = 110; exp_fw[2] = 120; exp_fw[3] = 110; exp_fw[4] = 100;
        exp_si[0] = 0;   exp_si[1] = 1;   exp_si[2] = 2;   exp_si[3] = 1;   exp_si[4] = 0;
        do_start(3, 100, 10, 2, 3);
        sweep_check("nom", 5, 8, 12);
`else
        exp_fw[0] = 100; exp_fw[1] = 110; exp_fw[2] = 120;
        exp_si[0] = 0;   exp_si[1] = 1;   exp_si[2] = 2;
        do_start(3, 100, 10, 2, 3);
        sweep_check("nom", 3, 8, 12);
`endif

        // Zero settle: LOAD straight into a 4-cycle dwell.
        exp_fw[0] = 500; exp_fw[1] = 507; exp_fw[2] = 500;
        exp_si[0] = 0;   exp_si[1] = 1;   exp_si[2] = 0;
        do_start(2, 500, 7, 0, 1);
`ifdef SWEEP_TRIANGLE_EN
        sweep_check("s0", 3, 0, 4);
`else
        sweep_check("s0", 2, 0, 4);
`endif

        // Frequency word wraps silently.
        exp_fw[0] = 32'hFFFF_FFF0; exp_fw[1] = 32'h0000_0010; exp_fw[2] = 32'hFFFF_FFF0;
        exp_si[0] = 0; exp_si[1] = 1; exp_si[2] = 0;
        do_start(2, 32'hFFFF_FFF0, 32'h20, 0, 1);
`ifdef SWEEP_TRIANGLE_EN
        sweep_check("wrap", 3, 0, 4);
`else
        sweep_check("wrap", 2, 0, 4);
`endif

        // Rejected configs.
        do_start(0, 1, 1, 1, 1);
        chk("cerr_n0", 32'(cfg_err), 1);
        chk("cerr_n0_busy", 32'(busy), 0);
        chk("cerr_n0_load", 32'(freq_load), 0);
        next_cyc();
        chk("cerr_n0_clr", 32'(cfg_err), 0);
        chk("cerr_n0_busy2", 32'(busy), 0);
        do_start(2, 1, 1, 1, 0);
        chk("cerr_d0", 32'(cfg_err), 1);
        chk("cerr_d0_busy", 32'(busy), 0);
        next_cyc();
        chk("cerr_d0_clr", 32'(cfg_err), 0);
        chk("cerr_d0_load", 32'(freq_load), 0);

        // abort beats start in IDLE.
        abort = 1'b1;
        do_start(2, 1, 1, 1, 1);
        abort = 1'b0;
        chk("ab_st_busy", 32'(busy), 0);
        chk("ab_st_cerr", 32'(cfg_err), 0);

        // Abort during step-1 dwell (c31-42), at c33.
        do_start(3, 100, 10, 2, 3);
        for (int k = 1; k < 33; k++) next_cyc();
        chk("ab_pre_samp", 32'(sample_en), 1);
        chk("ab_pre_idx", 32'(step_idx), 1);
        abort = 1'b1;
        next_cyc();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_samp", 32'(sample_en), 0);
        chk("ab_fw_hold", freq_word, 110);
        chk("ab_idx_hold", 32'(step_idx), 1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ab_nodone%0d", k), 32'(sweep_done | freq_load | step_done), 0);
            next_cyc();
        end
        do_start(1, 42, 1, 0, 1);
        chk("ab_restart_load", 32'(freq_load), 1);
        chk("ab_restart_fw", freq_word, 42);
        chk("ab_restart_idx", 32'(step_idx), 0);

        // Async reset mid-sweep.
        for (int k = 0; k < 10; k++) next_cyc();
        do_start(3, 300, 5, 1, 1);
        for (int k = 0; k < 7; k++) next_cyc();
        chk("ar_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 0);
        chk("ar_fw", freq_word, 0);
        chk("ar_idx", 32'(step_idx), 0);
        chk("ar_samp", 32'(sample_en), 0);
        #1 rst_n = 1'b1;
        next_cyc();
        chk("ar_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
